// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: word type, instruction-cache frame address layout and FSM states.
// The layout constants below describe the default 16-frame instruction cache.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   localparam int ICACHE_SETS = 16;
   localparam int IIDX_W      = $clog2(ICACHE_SETS);
   localparam int ITAG_W      = 30 - IIDX_W;

   typedef struct packed {
      logic [ITAG_W-1:0] tag;
      logic [IIDX_W-1:0] idx;
      logic [1:0]        bytoff;
   } icachef_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

   // Counters hold at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] r;
      if (v == 16'hFFFF) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a single outstanding fill.
// Hits return data in the same cycle; misses fetch through iREN/iaddr until iwait drops.
module icache
   import cpu_types_pkg::*;
#(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        iflush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   icache_state_t     state_r;
   logic [31:0]       miss_addr_r;
   logic [SETS-1:0]   valid_r;
   logic [TAG_W-1:0]  tag_r  [SETS];
   word_t             data_r [SETS];

   logic [IDX_W-1:0]  idx_s;
   logic [TAG_W-1:0]  tag_s;
   logic [IDX_W-1:0]  miss_idx_s;
   logic [TAG_W-1:0]  miss_tag_s;
   logic              miss_s;
   logic              fill_s;
   logic              unused_bits_s;

   assign idx_s         = imemaddr[IDX_W+1:2];
   assign tag_s         = imemaddr[31:IDX_W+2];
   assign miss_idx_s    = miss_addr_r[IDX_W+1:2];
   assign miss_tag_s    = miss_addr_r[31:IDX_W+2];
   assign unused_bits_s = ^imemaddr[1:0];

   // Lookup, miss detection, fill qualification and CPU/memory-side outputs.
   always_comb begin
      ihit     = 1'b0;
      imemload = 32'h0000_0000;
      iREN     = 1'b0;
      iaddr    = 32'h0000_0000;
      miss_s   = 1'b0;
      fill_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (imemREN && !iflush && valid_r[idx_s] && (tag_r[idx_s] == tag_s)) begin
               ihit     = 1'b1;
               imemload = data_r[idx_s];
            end else begin
               miss_s = imemREN & ~iflush;
            end
         end
         FETCH: begin
            iREN   = 1'b1;
            iaddr  = miss_addr_r;
            // A flush or a dropped request abandons the fill, even if data arrives now.
            fill_s = imemREN & ~iwait & ~iflush;
         end
         default: begin
            iREN = 1'b0;
         end
      endcase
   end

   // Controller state, latched miss address, valid bits and statistics counters.
   always_ff @(posedge CLK, negedge nRST) begin
      if (!nRST) begin
         state_r     <= IDLE;
         miss_addr_r <= 32'h0000_0000;
         valid_r     <= {SETS{1'b0}};
         hit_count   <= 16'h0000;
         miss_count  <= 16'h0000;
      end else begin
         if (ihit) begin
            hit_count <= sat_inc16(hit_count);
         end
         case (state_r)
            IDLE: begin
               if (miss_s) begin
                  state_r     <= FETCH;
                  miss_addr_r <= {imemaddr[31:2], 2'b00};
                  miss_count  <= sat_inc16(miss_count);
               end
            end
            FETCH: begin
               if (iflush || !imemREN || !iwait) begin
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
         if (iflush) begin
            valid_r <= {SETS{1'b0}};
         end else if (fill_s) begin
            valid_r[miss_idx_s] <= 1'b1;
         end
      end
   end

   // Tag and data arrays need no reset; the valid bits guard them.
   always_ff @(posedge CLK) begin
      if (fill_s) begin
         tag_r[miss_idx_s]  <= miss_tag_s;
         data_r[miss_idx_s] <= iload;
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a vector table for hit/miss/conflict traffic plus
// hand-written sequences for abort, flush, reset during a fill and counter saturation.
module tb_icache;

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        iflush;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int checks;
   int failures;

   icache #(.SETS(16)) dut (
      .CLK        (CLK),
      .nRST       (nRST),
      .imemREN    (imemREN),
      .imemaddr   (imemaddr),
      .iflush     (iflush),
      .ihit       (ihit),
      .imemload   (imemload),
      .iREN       (iREN),
      .iaddr      (iaddr),
      .iwait      (iwait),
      .iload      (iload),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        ren;
      logic [31:0] addr;
      logic        flush;
      logic        wt;
      logic [31:0] load;
      logic        e_hit;
      logic [31:0] e_data;
      logic        e_ren;
      logic [31:0] e_iaddr;
      logic [15:0] e_miss;
   } vec_t;

   vec_t vecs [20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic apply(input logic ren, input logic [31:0] addr, input logic flush,
                        input logic wt, input logic [31:0] load);
      imemREN  = ren;
      imemaddr = addr;
      iflush   = flush;
      iwait    = wt;
      iload    = load;
      #2;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0;
      apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      tick();
      tick();
      nRST = 1'b1;
   endtask

   function automatic vec_t mk(input logic ren, input logic [31:0] addr, input logic wt,
                               input logic [31:0] load, input logic e_hit, input logic [31:0] e_data,
                               input logic e_ren, input logic [31:0] e_iaddr, input logic [15:0] e_miss);
      vec_t v;
      v.ren = ren; v.addr = addr; v.flush = 1'b0; v.wt = wt; v.load = load;
      v.e_hit = e_hit; v.e_data = e_data; v.e_ren = e_ren; v.e_iaddr = e_iaddr; v.e_miss = e_miss;
      return v;
   endfunction

   initial begin
      checks   = 0;
      failures = 0;

      // Cold miss on 0x44 with three busy cycles, then conflicts on index 1, then an address change mid-fetch.
      vecs[0]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd0);
      vecs[1]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44, 16'd1);
      vecs[2]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44, 16'd1);
      vecs[3]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h44, 16'd1);
      vecs[4]  = mk(1'b1, 32'h44, 1'b0, 32'h8C220004, 1'b0, 32'h0,        1'b1, 32'h44, 16'd1);
      vecs[5]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b1, 32'h8C220004, 1'b0, 32'h0,  16'd1);
      vecs[6]  = mk(1'b1, 32'h04, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd1);
      vecs[7]  = mk(1'b1, 32'h04, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h04, 16'd2);
      vecs[8]  = mk(1'b1, 32'h04, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h0,  16'd2);
      vecs[9]  = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd2);
      vecs[10] = mk(1'b1, 32'h44, 1'b0, 32'h22222222, 1'b0, 32'h0,        1'b1, 32'h44, 16'd3);
      vecs[11] = mk(1'b1, 32'h44, 1'b1, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h0,  16'd3);
      vecs[12] = mk(1'b1, 32'h04, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd3);
      vecs[13] = mk(1'b1, 32'h04, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h04, 16'd4);
      vecs[14] = mk(1'b1, 32'h04, 1'b1, 32'h0,        1'b1, 32'h33333333, 1'b0, 32'h0,  16'd4);
      vecs[15] = mk(1'b1, 32'h83, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd4);
      vecs[16] = mk(1'b1, 32'h40, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h80, 16'd5);
      vecs[17] = mk(1'b1, 32'h40, 1'b0, 32'h55555555, 1'b0, 32'h0,        1'b1, 32'h80, 16'd5);
      vecs[18] = mk(1'b1, 32'h80, 1'b1, 32'h0,        1'b1, 32'h55555555, 1'b0, 32'h0,  16'd5);
      vecs[19] = mk(1'b0, 32'h80, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,  16'd5);

      // Reset state, with a request presented while nRST is low.
      nRST = 1'b0;
      apply(1'b1, 32'h44, 1'b0, 1'b1, 32'h0);
      tick();
      check("rst_ihit",     {31'h0, ihit},     32'h0);
      check("rst_imemload", imemload,          32'h0);
      check("rst_iren",     {31'h0, iREN},     32'h0);
      check("rst_iaddr",    iaddr,             32'h0);
      check("rst_hitcnt",   {16'h0, hit_count},  32'h0);
      check("rst_misscnt",  {16'h0, miss_count}, 32'h0);
      nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         apply(vecs[i].ren, vecs[i].addr, vecs[i].flush, vecs[i].wt, vecs[i].load);
         check($sformatf("v%0d_ihit", i),     {31'h0, ihit},       {31'h0, vecs[i].e_hit});
         check($sformatf("v%0d_imemload", i), imemload,            vecs[i].e_data);
         check($sformatf("v%0d_iren", i),     {31'h0, iREN},       {31'h0, vecs[i].e_ren});
         check($sformatf("v%0d_iaddr", i),    iaddr,               vecs[i].e_iaddr);
         check($sformatf("v%0d_misscnt", i),  {16'h0, miss_count}, {16'h0, vecs[i].e_miss});
         tick();
      end
      apply(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
      check("table_hitcnt",  {16'h0, hit_count},  32'd5);
      check("table_misscnt", {16'h0, miss_count}, 32'd5);

      // Abort: drop the request while the controller reports data in the same cycle.
      do_reset();
      apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
      check("abort_first_miss", {31'h0, ihit}, 32'h0);
      tick();
      apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
      check("abort_fetch_iren",  {31'h0, iREN}, 32'h1);
      check("abort_fetch_iaddr", iaddr,         32'h100);
      tick();
      apply(1'b0, 32'h100, 1'b0, 1'b0, 32'hDEADBEEF);
      tick();
      apply(1'b0, 32'h100, 1'b0, 1'b1, 32'h0);
      check("abort_idle_iren", {31'h0, iREN}, 32'h0);
      tick();
      apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
      check("abort_rereq_ihit", {31'h0, ihit}, 32'h0);
      tick();
      apply(1'b1, 32'h100, 1'b0, 1'b1, 32'h0);
      check("abort_refetch_iren", {31'h0, iREN},       32'h1);
      check("abort_misscnt",      {16'h0, miss_count}, 32'd2);

      // Flush during a completing fill: neither frame may survive.
      do_reset();
      apply(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
      tick();
      apply(1'b1, 32'h8, 1'b0, 1'b0, 32'hAAAA0008);
      tick();
      apply(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
      check("flush_pre_hit8", {31'h0, ihit}, 32'h1);
      check("flush_pre_data8", imemload,     32'hAAAA0008);
      tick();
      apply(1'b1, 32'hC, 1'b0, 1'b1, 32'h0);
      tick();
      apply(1'b1, 32'hC, 1'b1, 1'b0, 32'hBBBB000C);
      check("flush_fetch_iren", {31'h0, iREN}, 32'h1);
      tick();
      apply(1'b1, 32'hC, 1'b0, 1'b1, 32'h0);
      check("flush_c_miss", {31'h0, ihit}, 32'h0);
      tick();
      apply(1'b0, 32'hC, 1'b0, 1'b1, 32'h0);
      check("flush_c_refetch", {31'h0, iREN}, 32'h1);
      tick();
      apply(1'b1, 32'h8, 1'b0, 1'b1, 32'h0);
      check("flush_8_miss", {31'h0, ihit}, 32'h0);
      tick();
      apply(1'b0, 32'h8, 1'b0, 1'b1, 32'h0);
      check("flush_misscnt", {16'h0, miss_count}, 32'd4);
      tick();

      // Reset asserted in FETCH while data is on iload.
      do_reset();
      apply(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
      tick();
      apply(1'b1, 32'h200, 1'b0, 1'b0, 32'hCAFEF00D);
      check("rmid_iren_before", {31'h0, iREN}, 32'h1);
      nRST = 1'b0;
      #1;
      check("rmid_iren",  {31'h0, iREN}, 32'h0);
      check("rmid_iaddr", iaddr,         32'h0);
      check("rmid_ihit",  {31'h0, ihit}, 32'h0);
      check("rmid_load",  imemload,      32'h0);
      tick();
      nRST = 1'b1;
      apply(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
      check("rmid_after_miss", {31'h0, ihit}, 32'h0);
      tick();
      apply(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
      check("rmid_refetch", {31'h0, iREN}, 32'h1);

      // Saturation: one fill, then a hit held well past 65535 cycles.
      do_reset();
      apply(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
      tick();
      apply(1'b1, 32'h10, 1'b0, 1'b0, 32'h12345678);
      tick();
      apply(1'b1, 32'h10, 1'b0, 1'b1, 32'h0);
      for (int c = 0; c < 65540; c++) begin
         tick();
      end
      check("sat_ihit",    {31'h0, ihit},       32'h1);
      check("sat_hitcnt",  {16'h0, hit_count},  32'h0000FFFF);
      check("sat_misscnt", {16'h0, miss_count}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, default 16, number of direct-mapped one-word frames; power of two, 2..64.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 imemREN  input  1  CPU instruction read request.
REQ-005 imemaddr  input  32  CPU instruction byte address.
REQ-006 iflush  input  1  invalidate all frames.
REQ-007 ihit  output  1  imemload valid this cycle.
REQ-008 imemload  output  32  instruction returned to CPU.
REQ-009 iREN  output  1  fill request to the memory controller.
REQ-010 iaddr  output  32  word-aligned fill address.
REQ-011 iwait  input  1  memory controller busy; low for exactly the cycle iload is valid.
REQ-012 iload  input  32  fill data from the memory controller.
REQ-013 hit_count  output  16  saturating count of hit cycles.
REQ-014 miss_count  output  16  saturating count of fills started.

Function
REQ-015 Address split: byte offset [1:0] ignored; index = next log2(SETS) bits; tag = remaining upper bits.
REQ-016 Each frame holds valid bit, tag, 32-bit data word.
REQ-017 FSM states: IDLE, FETCH.
REQ-018 IDLE hit = imemREN & valid[idx] & tag match; ihit=1 and imemload=data[idx] combinationally, same cycle, zero latency.
REQ-019 IDLE miss (imemREN & !hit & !iflush) -> FETCH next edge; miss address latched (bits [1:0] forced 0); miss_count increments.
REQ-020 FETCH: iREN=1, iaddr=latched address, ihit=0, imemload=0.
REQ-021 FETCH with iwait=0: at that edge frame[latched idx] gets data=iload, tag=latched tag, valid=1; -> IDLE; the next cycle with the same imemaddr is a hit.
REQ-022 FETCH with iwait=1 and imemREN=1: remain in FETCH, no frame update.
REQ-023 FETCH with imemREN=0 (abort): -> IDLE next edge; no fill, even if iwait=0 the same cycle.
REQ-024 A change of imemaddr during FETCH does not affect iaddr or the fill target; the new address is evaluated in IDLE.
REQ-025 IDLE: iREN=0, iaddr=0.
REQ-026 iflush=1: all valid bits cleared at that edge; ihit forced 0 that cycle; in FETCH, -> IDLE with no fill (flush wins over a simultaneous fill).
REQ-027 hit_count increments on every cycle ihit=1; both counters saturate at 0xFFFF with no wrap.
REQ-028 Only one fill outstanding at a time; iREN never asserted in the cycle after a completing fill unless a new miss is detected.

Reset
REQ-029 nRST low: state=IDLE, all valid bits=0, latched address=0, hit_count=0, miss_count=0; data and tag arrays are not required to reset.
REQ-030 Outputs during reset: ihit=0, imemload=0, iREN=0, iaddr=0.
REQ-031 Reset asserted mid-FETCH abandons the fill immediately (asynchronous); no frame is written.

Structure
REQ-032 A frame-address typedef (tag/index/byte-offset struct) and the SETS-derived width constants reside in cpu_types_pkg beside the existing memory types.
REQ-033 Single module with no sub-module; the frame array is flip-flops inside icache.
REQ-034 icache is instantiated per core; iREN/iaddr/iwait/iload connect to one index of the controller's per-core ports.

Verification
REQ-035 Cold miss: imemREN=1, imemaddr=0x00000044, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN=1, iaddr=0x00000044 for 4 cycles; the next cycle ihit=1, imemload=0x8C220004; miss_count=1.
REQ-036 Conflict: fill 0x00000004 then request 0x00000044 (same index, different tag) -> miss and refill; a later request to 0x00000004 misses again; miss_count=3.
REQ-037 Abort: miss on 0x00000100, drop imemREN after 1 FETCH cycle while iwait=1 -> IDLE next cycle; a re-request of 0x00000100 misses; the frame stays invalid.
REQ-038 Flush: fill 0x00000008, pulse iflush while FETCH on 0x0000000C completes with iwait=0 -> both frames invalid; requests to 0x8 and 0xC both miss.
REQ-039 Saturation: hold a hit for 65540 cycles -> hit_count stops at 0xFFFF.
REQ-040 Reset mid-fill: assert nRST low in FETCH with iwait=0 -> outputs zero at once; after release, the original address misses.
